// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters for the 5-stage pipeline.
// Zero-latency lookup in F, training and mispredict detection from E, saturating perf counters.
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PredEn,
    input  logic [XLEN-1:0]  PCF,
    output logic             PredTakenF,
    output logic [XLEN-1:0]  PredTargetF,
    input  logic             UpdateE,
    input  logic [XLEN-1:0]  PCE,
    input  logic             TakenE,
    input  logic [XLEN-1:0]  TargetE,
    input  logic             PredTakenE,
    input  logic [XLEN-1:0]  PredTargetE,
    output logic             MispredictE,
    output logic [XLEN-1:0]  CorrectPCE,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] MispredCount
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - 2 - IDX_W;
    localparam logic [XLEN-1:0]  PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             valid_r  [ENTRIES];
    logic [TAG_W-1:0] tag_r    [ENTRIES];
    logic [XLEN-1:0]  target_r [ENTRIES];
    logic [1:0]       cnt_r    [ENTRIES];

    logic [CNT_W-1:0] branch_count_r;
    logic [CNT_W-1:0] mispred_count_r;

    logic [IDX_W-1:0] idx_f_s;
    logic [TAG_W-1:0] tag_f_s;
    logic             hit_f_s;
    logic             pred_taken_s;
    logic [IDX_W-1:0] idx_e_s;
    logic [TAG_W-1:0] tag_e_s;
    logic             hit_e_s;

    logic             wr_en_s;
    logic             wr_valid_s;
    logic [TAG_W-1:0] wr_tag_s;
    logic [XLEN-1:0]  wr_target_s;
    logic [1:0]       wr_cnt_s;

    assign idx_f_s = PCF[IDX_W+1:2];
    assign tag_f_s = PCF[XLEN-1:IDX_W+2];
    assign hit_f_s = valid_r[idx_f_s] & (tag_r[idx_f_s] == tag_f_s);

    assign idx_e_s = PCE[IDX_W+1:2];
    assign tag_e_s = PCE[XLEN-1:IDX_W+2];
    assign hit_e_s = valid_r[idx_e_s] & (tag_r[idx_e_s] == tag_e_s);

    // PredEn gates only the F-side outputs; the table keeps training underneath.
    assign pred_taken_s = PredEn & hit_f_s & cnt_r[idx_f_s][1];
    assign PredTakenF   = pred_taken_s;
    assign PredTargetF  = pred_taken_s ? target_r[idx_f_s] : (PCF + PC_STEP);

    assign MispredictE  = UpdateE & ((TakenE ^ PredTakenE) |
                          (TakenE & PredTakenE & (TargetE != PredTargetE)));
    assign CorrectPCE   = TakenE ? TargetE : (PCE + PC_STEP);

    assign BranchCount  = branch_count_r;
    assign MispredCount = mispred_count_r;

    // Next value of the E-indexed entry: allocate on taken miss, nudge counter on hit.
    always_comb begin
        wr_en_s     = 1'b0;
        wr_valid_s  = valid_r[idx_e_s];
        wr_tag_s    = tag_r[idx_e_s];
        wr_target_s = target_r[idx_e_s];
        wr_cnt_s    = cnt_r[idx_e_s];
        if (UpdateE) begin
            case ({hit_e_s, TakenE})
                2'b11: begin
                    wr_en_s     = 1'b1;
                    wr_target_s = TargetE;
                    wr_cnt_s    = (cnt_r[idx_e_s] == 2'b11) ? 2'b11 : (cnt_r[idx_e_s] + 2'b01);
                end
                2'b10: begin
                    wr_en_s     = 1'b1;
                    wr_cnt_s    = (cnt_r[idx_e_s] == 2'b00) ? 2'b00 : (cnt_r[idx_e_s] - 2'b01);
                end
                2'b01: begin
                    wr_en_s     = 1'b1;
                    wr_valid_s  = 1'b1;
                    wr_tag_s    = tag_e_s;
                    wr_target_s = TargetE;
                    wr_cnt_s    = 2'b10;
                end
                default: begin
                    wr_en_s     = 1'b0;
                end
            endcase
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Table storage; reset leaves every counter weakly not-taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {TAG_W{1'b0}};
                target_r[i] <= {XLEN{1'b0}};
                cnt_r[i]    <= 2'b01;
            end
        end else if (wr_en_s) begin
            valid_r[idx_e_s]  <= wr_valid_s;
            tag_r[idx_e_s]    <= wr_tag_s;
            target_r[idx_e_s] <= wr_target_s;
            cnt_r[idx_e_s]    <= wr_cnt_s;
        end
    end

    // Performance counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count_r  <= {CNT_W{1'b0}};
            mispred_count_r <= {CNT_W{1'b0}};
        end else begin
            if (UpdateE && (branch_count_r != CNT_MAX)) begin
                branch_count_r <= branch_count_r + CNT_ONE;
            end
            if (MispredictE && (mispred_count_r != CNT_MAX)) begin
                mispred_count_r <= mispred_count_r + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed test-plan scenarios plus randomized traffic against a behavioural model.
// A second instance with 4-bit perf counters shares all inputs to exercise counter saturation.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst, pred_en, upd, taken_e, ptaken_e;
    logic [31:0] pcf, pce, target_e, ptarget_e;
    logic        pred_taken_f, mispredict_e, s_pred_taken_f, s_mispredict_e;
    logic [31:0] pred_target_f, correct_pc_e, branch_count, mispred_count;
    logic [31:0] s_pred_target_f, s_correct_pc_e;
    logic [3:0]  s_branch_count, s_mispred_count;

    int checks = 0;
    int errors = 0;

    // Reference model: per-slot owner tag, target, and counter strength 0..3.
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_cnt   [16];
    longint      m_br, m_mp;

    branch_predictor dut (
        .clk(clk), .rst(rst), .PredEn(pred_en), .PCF(pcf),
        .PredTakenF(pred_taken_f), .PredTargetF(pred_target_f),
        .UpdateE(upd), .PCE(pce), .TakenE(taken_e), .TargetE(target_e),
        .PredTakenE(ptaken_e), .PredTargetE(ptarget_e),
        .MispredictE(mispredict_e), .CorrectPCE(correct_pc_e),
        .BranchCount(branch_count), .MispredCount(mispred_count)
    );

    branch_predictor #(.XLEN(32), .ENTRIES(16), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .PredEn(pred_en), .PCF(pcf),
        .PredTakenF(s_pred_taken_f), .PredTargetF(s_pred_target_f),
        .UpdateE(upd), .PCE(pce), .TakenE(taken_e), .TargetE(target_e),
        .PredTakenE(ptaken_e), .PredTargetE(ptarget_e),
        .MispredictE(s_mispredict_e), .CorrectPCE(s_correct_pc_e),
        .BranchCount(s_branch_count), .MispredCount(s_mispred_count)
    );

    always #5 clk = ~clk;

    function automatic int slot(logic [31:0] pc);
        return int'((pc / 32'd4) % 32'd16);
    endfunction

    function automatic logic [31:0] owner(logic [31:0] pc);
        return pc / 32'd64;
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_valid[slot(pc)] && (m_tag[slot(pc)] == owner(pc));
    endfunction

    function automatic bit m_pred_taken(logic [31:0] pc, bit en);
        return en && m_hit(pc) && (m_cnt[slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_target(logic [31:0] pc, bit en);
        return m_pred_taken(pc, en) ? m_tgt[slot(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_mispredict();
        if (!upd) return 1'b0;
        if (taken_e != ptaken_e) return 1'b1;
        return taken_e && (target_e != ptarget_e);
    endfunction

    function automatic logic [3:0] small_of(longint v);
        return (v > 64'd15) ? 4'd15 : v[3:0];
    endfunction

    task automatic model_apply();
        int i;
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                m_valid[k] = 1'b0; m_tag[k] = 32'd0; m_tgt[k] = 32'd0; m_cnt[k] = 1;
            end
            m_br = 0;
            m_mp = 0;
        end else if (upd) begin
            if (m_mispredict() && m_mp < 64'hFFFF_FFFF) m_mp++;
            if (m_br < 64'hFFFF_FFFF) m_br++;
            i = slot(pce);
            if (m_hit(pce)) begin
                if (taken_e) begin
                    m_cnt[i] = (m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1;
                    m_tgt[i] = target_e;
                end else begin
                    m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
                end
            end else if (taken_e) begin
                m_valid[i] = 1'b1; m_tag[i] = owner(pce); m_tgt[i] = target_e; m_cnt[i] = 2;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_apply();
        #1;
    endtask

    task automatic set_upd(bit u, logic [31:0] pc, bit t, logic [31:0] tg, bit pt, logic [31:0] ptg);
        upd = u; pce = pc; taken_e = t; target_e = tg; ptaken_e = pt; ptarget_e = ptg;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pred_en = 1'b1; pcf = 32'h40;
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL reset_taken got %0b exp 0", pred_taken_f); end
        checks++; if (pred_target_f !== 32'h44) begin errors++; $display("FAIL reset_target got %h exp 00000044", pred_target_f); end
        checks++; if (branch_count !== 32'd0 || mispred_count !== 32'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", branch_count, mispred_count); end
    endtask

    task automatic test_allocate();
        set_upd(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
        checks++; if (mispredict_e !== 1'b1) begin errors++; $display("FAIL alloc_mispredict got %0b exp 1", mispredict_e); end
        checks++; if (correct_pc_e !== 32'h80) begin errors++; $display("FAIL alloc_correct_pc got %h exp 00000080", correct_pc_e); end
        checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL alloc_no_bypass got %0b exp 0", pred_taken_f); end
        tick();
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL alloc_taken got %0b exp 1", pred_taken_f); end
        checks++; if (pred_target_f !== 32'h80) begin errors++; $display("FAIL alloc_target got %h exp 00000080", pred_target_f); end
        checks++; if (branch_count !== 32'd1 || mispred_count !== 32'd1) begin errors++; $display("FAIL alloc_counts got %0d/%0d exp 1/1", branch_count, mispred_count); end
    endtask

    task automatic test_hysteresis();
        for (int k = 0; k < 3; k++) begin
            set_upd(1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
            tick();
        end
        set_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
        tick();
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL hyst_one_nt got %0b exp 1", pred_taken_f); end
        set_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
        tick();
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (pred_taken_f !== 1'b0 || pred_target_f !== 32'h44) begin errors++; $display("FAIL hyst_two_nt got %0b/%h exp 0/00000044", pred_taken_f, pred_target_f); end
        checks++; if (branch_count !== 32'd6 || mispred_count !== 32'd3) begin errors++; $display("FAIL hyst_counts got %0d/%0d exp 6/3", branch_count, mispred_count); end
    endtask

    task automatic test_alias();
        set_upd(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
        tick();
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        pcf = 32'h80; #1;
        checks++; if (pred_taken_f !== 1'b0 || pred_target_f !== 32'h84) begin errors++; $display("FAIL alias_lookup got %0b/%h exp 0/00000084", pred_taken_f, pred_target_f); end
        set_upd(1'b1, 32'h80, 1'b1, 32'h100, 1'b0, 32'h84);
        tick();
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        pcf = 32'h40; #1;
        checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL alias_evicted got %0b exp 0", pred_taken_f); end
        pcf = 32'h80; #1;
        checks++; if (pred_taken_f !== 1'b1 || pred_target_f !== 32'h100) begin errors++; $display("FAIL alias_new_owner got %0b/%h exp 1/00000100", pred_taken_f, pred_target_f); end
    endtask

    task automatic test_wrong_target_and_pred_en();
        set_upd(1'b1, 32'h80, 1'b1, 32'hC0, 1'b1, 32'h80);
        checks++; if (mispredict_e !== 1'b1 || correct_pc_e !== 32'hC0) begin errors++; $display("FAIL wrong_target got %0b/%h exp 1/000000c0", mispredict_e, correct_pc_e); end
        tick();
        set_upd(1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'hC0);
        checks++; if (mispredict_e !== 1'b1 || correct_pc_e !== 32'h84) begin errors++; $display("FAIL not_taken_redirect got %0b/%h exp 1/00000084", mispredict_e, correct_pc_e); end
        set_upd(1'b1, 32'h80, 1'b1, 32'h200, 1'b1, 32'h200);
        checks++; if (mispredict_e !== 1'b0) begin errors++; $display("FAIL correct_pred got %0b exp 0", mispredict_e); end
        pred_en = 1'b0; pcf = 32'h80; #1;
        checks++; if (pred_taken_f !== 1'b0 || pred_target_f !== 32'h84) begin errors++; $display("FAIL pred_en_off got %0b/%h exp 0/00000084", pred_taken_f, pred_target_f); end
        tick();
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        pred_en = 1'b1; #1;
        checks++; if (pred_taken_f !== 1'b1 || pred_target_f !== 32'h200) begin errors++; $display("FAIL pred_en_trained got %0b/%h exp 1/00000200", pred_taken_f, pred_target_f); end
        pcf = 32'hFFFF_FFFC; #1;
        checks++; if (pred_target_f !== 32'h0) begin errors++; $display("FAIL pc_wrap got %h exp 00000000", pred_target_f); end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 20; k++) begin
            set_upd(1'b1, 32'($urandom_range(0, 63)) * 32'd4, 1'b1, 32'h300, 1'b0, 32'h0);
            tick();
        end
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (s_branch_count !== 4'd15 || s_mispred_count !== 4'd15) begin errors++; $display("FAIL small_saturate got %0d/%0d exp 15/15", s_branch_count, s_mispred_count); end
        checks++; if (branch_count !== 32'(m_br) || mispred_count !== 32'(m_mp)) begin errors++; $display("FAIL wide_counts got %0d/%0d exp %0d/%0d", branch_count, mispred_count, m_br, m_mp); end
    endtask

    task automatic test_reset_mid_update();
        pcf = 32'h300;
        set_upd(1'b1, 32'h300, 1'b1, 32'h400, 1'b0, 32'h0);
        rst = 1'b1; #1;
        checks++; if (mispredict_e !== 1'b1) begin errors++; $display("FAIL reset_comb_mispredict got %0b exp 1", mispredict_e); end
        tick();
        rst = 1'b0;
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (branch_count !== 32'd0 || mispred_count !== 32'd0 || s_branch_count !== 4'd0 || s_mispred_count !== 4'd0) begin errors++; $display("FAIL reset_mid_counts got %0d/%0d/%0d/%0d exp 0/0/0/0", branch_count, mispred_count, s_branch_count, s_mispred_count); end
        for (int k = 0; k < 64; k++) begin
            pcf = 32'(k) * 32'd4; #1;
            checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL reset_mid_table pc=%h got %0b exp 0", pcf, pred_taken_f); end
        end
    endtask

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFC0 + 32'($urandom_range(0, 15)) * 32'd4;
        return 32'($urandom_range(0, 63)) * 32'd4;
    endfunction

    task automatic test_random();
        logic [31:0] pc;
        for (int n = 0; n < 2000; n++) begin
            rst     = ($urandom_range(0, 63) == 0);
            pred_en = ($urandom_range(0, 7) != 0);
            pcf     = rand_pc();
            pc      = rand_pc();
            upd = ($urandom_range(0, 3) != 0); pce = pc; taken_e = $urandom_range(0, 1);
            target_e = 32'h1000 + 32'($urandom_range(0, 3)) * 32'h40;
            if ($urandom_range(0, 3) != 0) begin
                ptaken_e = m_pred_taken(pc, 1'b1); ptarget_e = m_pred_target(pc, 1'b1);
            end else begin
                ptaken_e = $urandom_range(0, 1);
                ptarget_e = 32'h1000 + 32'($urandom_range(0, 3)) * 32'h40;
            end
            #1;
            checks++; if (pred_taken_f !== m_pred_taken(pcf, pred_en)) begin errors++; $display("FAIL rnd_taken n=%0d pc=%h got %0b exp %0b", n, pcf, pred_taken_f, m_pred_taken(pcf, pred_en)); end
            checks++; if (pred_target_f !== m_pred_target(pcf, pred_en)) begin errors++; $display("FAIL rnd_target n=%0d pc=%h got %h exp %h", n, pcf, pred_target_f, m_pred_target(pcf, pred_en)); end
            checks++; if (mispredict_e !== m_mispredict()) begin errors++; $display("FAIL rnd_mispredict n=%0d got %0b exp %0b", n, mispredict_e, m_mispredict()); end
            checks++; if (correct_pc_e !== (taken_e ? target_e : pce + 32'd4)) begin errors++; $display("FAIL rnd_correct_pc n=%0d got %h", n, correct_pc_e); end
            checks++; if (branch_count !== 32'(m_br) || mispred_count !== 32'(m_mp)) begin errors++; $display("FAIL rnd_counts n=%0d got %0d/%0d exp %0d/%0d", n, branch_count, mispred_count, m_br, m_mp); end
            checks++; if (s_branch_count !== small_of(m_br) || s_mispred_count !== small_of(m_mp)) begin errors++; $display("FAIL rnd_small_counts n=%0d got %0d/%0d exp %0d/%0d", n, s_branch_count, s_mispred_count, small_of(m_br), small_of(m_mp)); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_hysteresis();
        test_alias();
        test_wrong_target_and_pred_en();
        test_saturation();
        test_reset_mid_update();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
